rf_write_arbiter: RTL and testbench

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

---
 rtl/rf_write_arbiter.sv | 101 ++++++++++
 tb/tb_rf_write_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// Two-requester register-file writeback arbiter with a destination scoreboard.
// Round-robin on contention, one registered write per cycle, pending mask for hazard checks.
module rf_sb_cell (
  input  logic Clk,
  input  logic Clr,
  input  logic set,
  input  logic clr,
  output logic q
);
  // A new reservation outranks the retiring write of an older producer.
  always_ff @(posedge Clk or negedge Clr)
    if (!Clr)     q <= 1'b0;
    else if (set) q <= 1'b1;
    else if (clr) q <= 1'b0;
endmodule

module rf_write_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int REG_W    = 5,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              req0_valid,
  input  logic [REG_W-1:0]  req0_rd,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [REG_W-1:0]  req1_rd,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic [REG_W-1:0]  RD,
  output logic [DATA_W-1:0] dataRD,
  output logic              RW,
  input  logic              rsv_valid,
  input  logic [REG_W-1:0]  rsv_rd,
  input  logic [REG_W-1:0]  chk_rs,
  input  logic [REG_W-1:0]  chk_rt,
  output logic              hazard_rs,
  output logic              hazard_rt,
  output logic [NUM_REGS-1:0] pending
);
  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  logic    [NUM_REQ-1:0] vld;
  logic    [NUM_REQ-1:0] gnt;
  wb_req_t [NUM_REQ-1:0] req;
  wb_req_t               sel;
  logic                  prio;
  logic                  xfer;
  logic                  contested;

  assign vld    = {req1_valid, req0_valid};
  assign req[0] = '{rd: req0_rd, data: req0_data};
  assign req[1] = '{rd: req1_rd, data: req1_data};

  // prio names the requester that wins when both are valid.
  assign contested = &vld;
  assign gnt[0]    = vld[0] && (!vld[1] || !prio);
  assign gnt[1]    = vld[1] && (!vld[0] ||  prio);
  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign xfer       = |gnt;
  assign sel        = gnt[1] ? req[1] : req[0];

  always_ff @(posedge Clk or negedge Clr)
    if (!Clr)           prio <= 1'b0;
    else if (contested) prio <= gnt[0];

  // Writes to r0 are consumed but never reach the register file.
  always_ff @(posedge Clk or negedge Clr)
    if (!Clr) begin
      RW     <= 1'b0;
      RD     <= '0;
      dataRD <= '0;
    end else if (xfer && (sel.rd != '0)) begin
      RW     <= 1'b1;
      RD     <= sel.rd;
      dataRD <= sel.data;
    end else begin
      RW     <= 1'b0;
    end

  assign pending[0] = 1'b0;
  for (genvar i = 1; i < NUM_REGS; i++) begin : g_sb
    rf_sb_cell u_cell (
      .Clk (Clk),
      .Clr (Clr),
      .set (rsv_valid && (rsv_rd == REG_W'(i))),
      .clr (RW && (RD == REG_W'(i))),
      .q   (pending[i])
    );
  end

  assign hazard_rs = pending[chk_rs];
  assign hazard_rt = pending[chk_rt];
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized scoreboard bench for rf_write_arbiter: driver predicts, monitor compares writes.
module tb_rf_write_arbiter;
  logic        Clk = 1'b0;
  logic        Clr;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [4:0]  req0_rd, req1_rd, RD, rsv_rd, chk_rs, chk_rt;
  logic [31:0] req0_data, req1_data, dataRD, pending;
  logic        RW, rsv_valid, hazard_rs, hazard_rt;

  always #5 Clk = ~Clk;

  rf_write_arbiter dut (
    .Clk(Clk), .Clr(Clr),
    .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(req1_ready),
    .RD(RD), .dataRD(dataRD), .RW(RW),
    .rsv_valid(rsv_valid), .rsv_rd(rsv_rd), .chk_rs(chk_rs), .chk_rt(chk_rt),
    .hazard_rs(hazard_rs), .hazard_rt(hazard_rt), .pending(pending)
  );

  typedef struct {
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] pend;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;

  // Reference state: who lost the last contest, which registers await a write, last landed write.
  bit        m_loser;
  bit [31:0] m_pend;
  bit        m_rw;
  bit [4:0]  m_rd;
  bit [31:0] m_data;
  bit        last_g0, last_g1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_loser = 1'b0; m_pend = '0; m_rw = 1'b0; m_rd = '0; m_data = '0;
  endtask

  task automatic idle();
    req0_valid = 0; req1_valid = 0; rsv_valid = 0;
    req0_rd = 0; req1_rd = 0; req0_data = 0; req1_data = 0; rsv_rd = 0;
    chk_rs = 0; chk_rt = 0;
  endtask

  // Called 1 time unit after a rising edge with inputs applied; returns at the same phase next cycle.
  task automatic step();
    bit        g0, g1;
    bit [31:0] npend;
    #1;
    g0 = req0_valid && (!req1_valid || m_loser == 1'b0);
    g1 = req1_valid && !g0;
    chk("ready0", req0_ready, g0);
    chk("ready1", req1_ready, g1);
    chk("hazard_rs", hazard_rs, (chk_rs == 0) ? 1'b0 : m_pend[chk_rs]);
    chk("hazard_rt", hazard_rt, (chk_rt == 0) ? 1'b0 : m_pend[chk_rt]);
    last_g0 = g0; last_g1 = g1;
    npend = m_pend;
    if (m_rw) npend[m_rd] = 1'b0;
    if (rsv_valid && rsv_rd != 0) npend[rsv_rd] = 1'b1;
    npend[0] = 1'b0;
    if (req0_valid && req1_valid) m_loser = g0 ? 1'b1 : 1'b0;
    if (g0 && req0_rd != 0)      begin m_rw = 1; m_rd = req0_rd; m_data = req0_data; end
    else if (g1 && req1_rd != 0) begin m_rw = 1; m_rd = req1_rd; m_data = req1_data; end
    else m_rw = 0;
    m_pend = npend;
    if (mon_en) q.push_back('{rw: m_rw, rd: m_rd, data: m_data, pend: m_pend});
    @(posedge Clk); #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge Clk); #1;
      if (mon_en && q.size() > 0) begin
        e = q.pop_front();
        chk("mon_rw", RW, e.rw);
        if (e.rw) begin
          chk("mon_rd", RD, e.rd);
          chk("mon_data", dataRD, e.data);
        end
        chk("mon_pending", pending, e.pend);
      end
    end
  end

  initial begin : driver
    idle();
    Clr = 1'b0;
    model_reset();
    #2;
    chk("rst_rw", RW, 0);
    chk("rst_rd", RD, 0);
    chk("rst_data", dataRD, 0);
    chk("rst_pending", pending, 0);
    @(posedge Clk); @(posedge Clk); #1;
    Clr = 1'b1;
    mon_en = 1'b1;

    // Single requester after reset.
    req0_valid = 1; req0_rd = 5; req0_data = 32'hDEADBEEF;
    step();
    chk("wb_rw", RW, 1); chk("wb_rd", RD, 5); chk("wb_data", dataRD, 32'hDEADBEEF);
    idle();
    step();
    chk("wb_rw_drop", RW, 0);

    // Sustained contention alternates grants 0,1,0,1.
    for (int k = 0; k < 4; k++) begin
      req0_valid = 1; req0_rd = 1; req0_data = 32'hA000_0000 + k;
      req1_valid = 1; req1_rd = 2; req1_data = 32'hB000_0000 + k;
      step();
      chk("rr_rd", RD, (k % 2) ? 5'd2 : 5'd1);
    end
    idle();

    // r0 write is consumed but never lands.
    req1_valid = 1; req1_rd = 0; req1_data = 32'h12345678;
    step();
    chk("r0_rw", RW, 0);
    chk("r0_pending", pending, 0);
    idle();

    // Reservation, hazard, then clearing write.
    rsv_valid = 1; rsv_rd = 7;
    step();
    idle(); chk_rs = 7;
    #1;
    chk("hz_set", hazard_rs, 1);
    chk("hz_pending", pending, 32'h0000_0080);
    req0_valid = 1; req0_rd = 7; req0_data = 32'h7777_7777;
    step();
    req0_valid = 0;
    #1;
    chk("hz_during_rw", hazard_rs, 1);
    step();
    chk("hz_cleared", hazard_rs, 0);
    idle();

    // Re-reservation wins against the landing write of the same index.
    req0_valid = 1; req0_rd = 9; req0_data = 32'h9999_9999;
    step();
    idle(); rsv_valid = 1; rsv_rd = 9;
    step();
    chk("set_wins", pending[9], 1);
    idle();

    // Build pending = 0xFFFE, launch a contested write, then reset under it.
    for (int r = 1; r < 16; r++) begin
      rsv_valid = 1; rsv_rd = r[4:0];
      step();
    end
    idle();
    req0_valid = 1; req0_rd = 3; req0_data = 32'h3333_3333;
    req1_valid = 1; req1_rd = 4; req1_data = 32'h4444_4444;
    step();
    chk("pre_rst_rw", RW, 1);
    chk("pre_rst_pending", pending, 32'h0000_FFFE);
    mon_en = 1'b0;
    q.delete();
    Clr = 1'b0;
    #1;
    chk("mid_rst_rw", RW, 0);
    chk("mid_rst_pending", pending, 0);
    chk("mid_rst_ready0", req0_ready, 1);
    chk("mid_rst_ready1", req1_ready, 0);
    @(posedge Clk); #1;
    chk("rst_hold_rw", RW, 0);
    chk("rst_hold_pending", pending, 0);
    Clr = 1'b1;
    model_reset();
    mon_en = 1'b1;
    idle();

    // Random traffic; ungranted requests are held stable.
    last_g0 = 0; last_g1 = 0;
    for (int c = 0; c < 500; c++) begin
      if (!(req0_valid && !last_g0)) begin
        req0_valid = ($urandom_range(0, 3) != 0);
        req0_rd = 5'($urandom_range(0, 31)); req0_data = $urandom;
      end
      if (!(req1_valid && !last_g1)) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_rd = 5'($urandom_range(0, 31)); req1_data = $urandom;
      end
      rsv_valid = ($urandom_range(0, 2) == 0);
      rsv_rd = 5'($urandom_range(0, 31));
      chk_rs = 5'($urandom_range(0, 31));
      chk_rt = 5'($urandom_range(0, 31));
      step();
    end
    idle();
    step();
    step();
    if (q.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain: %0d expected writes never observed", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $fatal(1);
  end
endmodule
